// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry constants and shared piece/row types for the pixel pipeline.
package tetris_pkg;
   localparam int BOARD_X0   = 240;
   localparam int BOARD_Y0   = 80;
   localparam int CELL_LOG2  = 4;
   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 20;
   localparam int VBLANK_Y   = 480;
   typedef logic [9:0] board_row_t;
   typedef struct packed {
      logic [15:0]        mask;
      logic signed [4:0]  col;
      logic signed [5:0]  row;
   } piece_t;
endpackage

// File: rtl/piece_shadow_reg.sv
// piece_shadow_reg: double-buffered active piece; pending is copied to committed only at the commit point.
module piece_shadow_reg
   import tetris_pkg::*;
(
   input  logic   Clk,
   input  logic   Reset_n,
   input  logic   commit,
   input  logic   we,
   input  piece_t next_piece,
   output logic   pending,
   output piece_t committed
);
   piece_t pend;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pend      <= '0;
         committed <= '0;
         pending   <= 1'b0;
      end else begin
         pend      <= we ? next_piece : pend;
         // a write landing on the commit cycle bypasses the pending slot
         committed <= (commit && we) ? next_piece : (commit && pending) ? pend : committed;
         pending   <= !commit && (we || pending);
      end
   end
endmodule

// File: rtl/board_pixel_gen.sv
// board_pixel_gen: two-stage pixel pipeline deciding whether the current pixel
// lies on a settled board cell or on a cell of the committed falling piece.
module board_pixel_gen
   import tetris_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [4:0]  row_addr,
   input  board_row_t  row_data,
   input  logic        piece_we,
   input  logic [15:0] piece_mask,
   input  logic [4:0]  piece_col,
   input  logic [5:0]  piece_row,
   output logic        piece_pending,
   output logic        is_block,
   output logic [9:0]  DrawX_d,
   output logic [9:0]  DrawY_d
);
   logic [10:0] dx, dy;
   logic        in_board, board_hit, piece_hit;
   logic [3:0]  col, s1_col;
   logic [4:0]  row, s1_row;
   logic        s1_in;
   logic [9:0]  s1_x, s1_y;
   logic [6:0]  pr, pc;
   piece_t      cur;
   piece_shadow_reg u_shadow (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .commit     (DrawY == 10'(VBLANK_Y) && DrawX == 10'd0),
      .we         (piece_we),
      .next_piece ({piece_mask, piece_col, piece_row}),
      .pending    (piece_pending),
      .committed  (cur)
   );
   // negative offsets wrap to large unsigned values, so one compare covers both bounds
   always_comb begin
      dx       = {1'b0, DrawX} - 11'(BOARD_X0);
      dy       = {1'b0, DrawY} - 11'(BOARD_Y0);
      in_board = dx < 11'(BOARD_COLS << CELL_LOG2) && dy < 11'(BOARD_ROWS << CELL_LOG2);
      col      = 4'(dx >> CELL_LOG2);
      row      = 5'(dy >> CELL_LOG2);
      row_addr = in_board ? row : 5'd0;
   end
   always_comb begin
      board_hit = row_data[s1_col];
      pr        = {2'b00, s1_row} - {cur.row[5], cur.row};
      pc        = {3'b000, s1_col} - {{2{cur.col[4]}}, cur.col};
      piece_hit = pr[6:2] == 5'd0 && pc[6:2] == 5'd0 && cur.mask[{pr[1:0], pc[1:0]}];
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_in    <= 1'b0;
         s1_col   <= '0;
         s1_row   <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         is_block <= 1'b0;
         DrawX_d  <= '0;
         DrawY_d  <= '0;
      end else begin
         s1_in    <= in_board;
         s1_col   <= col;
         s1_row   <= row;
         s1_x     <= DrawX;
         s1_y     <= DrawY;
         is_block <= s1_in && (board_hit || piece_hit);
         DrawX_d  <= s1_x;
         DrawY_d  <= s1_y;
      end
   end
endmodule

// File: tb/tb_board_pixel_gen.sv
// tb_board_pixel_gen: scoreboarded random and directed pixel stimulus against a cell-level board/piece model.
module tb_board_pixel_gen;
   import tetris_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [9:0]  draw_x = '0, draw_y = '0, draw_x_d, draw_y_d;
   logic [4:0]  row_addr;
   logic [9:0]  row_data = '0;
   logic        piece_we = 1'b0;
   logic [15:0] piece_mask = '0;
   logic [4:0]  piece_col = '0;
   logic [5:0]  piece_row = '0;
   logic        piece_pending, is_block;
   board_pixel_gen dut (
      .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y),
      .row_addr(row_addr), .row_data(row_data), .piece_we(piece_we),
      .piece_mask(piece_mask), .piece_col(piece_col), .piece_row(piece_row),
      .piece_pending(piece_pending), .is_block(is_block),
      .DrawX_d(draw_x_d), .DrawY_d(draw_y_d)
   );
   always #5 clk = ~clk;
   logic [9:0] ram [20];
   always @(posedge clk) row_data <= ram[row_addr];
   typedef struct { int x; int y; bit blk; int due; } exp_t;
   exp_t q[$];
   int vectors = 0, miscompares = 0, cyc = 0;
   int m_mask = 0, m_col = 0, m_row = 0, p_mask = 0, p_col = 0, p_row = 0;
   bit p_valid = 0;
   localparam int CS = 1 << CELL_LOG2;
   function automatic bit on_board(int x, int y);
      return x >= BOARD_X0 && x < BOARD_X0 + BOARD_COLS * CS && y >= BOARD_Y0 && y < BOARD_Y0 + BOARD_ROWS * CS;
   endfunction
   function automatic int ref_addr(int x, int y);
      return on_board(x, y) ? (y - BOARD_Y0) / CS : 0;
   endfunction
   function automatic bit ref_block(int x, int y);
      int c, r;
      if (!on_board(x, y)) return 0;
      c = (x - BOARD_X0) / CS;
      r = (y - BOARD_Y0) / CS;
      if (ram[r][c]) return 1;
      for (int i = 0; i < 16; i++)
         if (m_mask[i] && m_row + i / 4 == r && m_col + i % 4 == c) return 1;
      return 0;
   endfunction
   task automatic check(string name, int act, int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask
   task automatic pix(int x, int y, bit we = 0, int msk = 0, int pc = 0, int pr = 0);
      bit commit;
      @(negedge clk);
      check("piece_pending", int'(piece_pending), int'(p_valid));
      draw_x = x[9:0]; draw_y = y[9:0]; piece_we = we;
      piece_mask = msk[15:0]; piece_col = pc[4:0]; piece_row = pr[5:0];
      #1 check("row_addr", int'(row_addr), ref_addr(x, y));
      commit = (y == VBLANK_Y && x == 0);
      if (commit) begin
         if (we) begin m_mask = msk; m_col = pc; m_row = pr; end
         else if (p_valid) begin m_mask = p_mask; m_col = p_col; m_row = p_row; end
         p_valid = 0;
      end
      if (we) begin
         p_mask = msk; p_col = pc; p_row = pr;
         if (!commit) p_valid = 1;
      end
      q.push_back('{x, y, ref_block(x, y), cyc + 2});
   endtask
   task automatic sweep(int y0, int y1, int ys, int x0, int x1, int xs);
      for (int y = y0; y <= y1; y += ys)
         for (int x = x0; x <= x1; x += xs) pix(x, y);
   endtask
   task automatic ram_write(int r, int v);
      @(negedge clk);
      piece_we = 1'b0;
      ram[r] = v[9:0];
   endtask
   task automatic do_reset();
      @(negedge clk);
      piece_we = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_is_block", int'(is_block), 0);
      check("reset_x_d", int'(draw_x_d), 0);
      check("reset_y_d", int'(draw_y_d), 0);
      check("reset_pending", int'(piece_pending), 0);
      q.delete();
      m_mask = 0; m_col = 0; m_row = 0; p_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         vectors++;
         if (is_block !== e.blk || draw_x_d !== e.x[9:0] || draw_y_d !== e.y[9:0]) begin
            miscompares++;
            $display("FAIL pixel(%0d,%0d): is_block=%0b x_d=%0d y_d=%0d, expected is_block=%0b x_d=%0d y_d=%0d",
                     e.x, e.y, is_block, draw_x_d, draw_y_d, e.blk, e.x, e.y);
         end
      end
   end
   initial begin
      for (int i = 0; i < 20; i++) ram[i] = '0;
      #12;
      check("init_is_block", int'(is_block), 0);
      check("init_x_d", int'(draw_x_d), 0);
      check("init_y_d", int'(draw_y_d), 0);
      check("init_pending", int'(piece_pending), 0);
      @(negedge clk) rst_n = 1'b1;
      sweep(0, 524, 5, 0, 799, 9);
      ram_write(19, 10'h001);
      pix(240, 384); pix(256, 384); pix(239, 384); pix(255, 399); pix(240, 400);
      pix(0, 300, 1, 16'h000F, 3, 0);
      pix(0, 480);
      sweep(80, 95, 3, 280, 360, 1);
      pix(10, 100, 1, 16'h1111, -2, 5);
      pix(0, 480);
      sweep(160, 239, 4, 240, 399, 4);
      pix(0, 300, 1, 16'h0033, 4, 8);
      pix(0, 480);
      pix(10, 200, 1, 16'hF000, 0, 15);
      sweep(200, 479, 3, 240, 399, 5);
      pix(0, 480);
      sweep(80, 400, 4, 240, 399, 6);
      pix(0, 480, 1, 16'h0660, 5, 10);
      sweep(240, 271, 2, 300, 360, 2);
      pix(240, 384); pix(256, 384);
      do_reset();
      sweep(80, 399, 8, 240, 399, 4);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(49) == 0) ram_write($urandom_range(19), $urandom_range(1023));
         if ($urandom_range(39) == 0)
            pix($urandom_range(410, 230), $urandom_range(410, 70), 1, $urandom_range(65535),
                int'($urandom_range(15)) - 3, int'($urandom_range(25)) - 3);
         else if ($urandom_range(99) == 0) pix(0, 480, $urandom_range(1));
         else pix($urandom_range(410, 230), $urandom_range(410, 70));
      end
      @(negedge clk) piece_we = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d outputs outstanding, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
